// File: rtl/one_wire_master.sv
// one_wire_master: 1-Wire bus initiator (standard speed).
// Generates reset/presence, write and read time slots on an open-drain line
// and turns byte-level commands into bus traffic, returning presence status
// and read bytes. All slot times are N_us * CLKS_PER_US clock cycles.
//
// Optional feature macro: ONE_WIRE_CRC_EN adds crc_out[7:0], a Dallas CRC-8
// over every bit written or read, cleared by rst and by a bus-reset command.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   cmd_valid/ready     command handshake (ready only in IDLE)
//   cmd_op[1:0]         00 bus reset, 01 write byte, 10 read byte, 11 no-op
//   cmd_data[7:0]       byte to write (LSB first), latched at accept
//   rsp_valid           one-cycle completion pulse
//   rsp_data[7:0]       read byte (0 for other ops), held until next rsp_valid
//   presence            presence result of the last bus reset
//   busy                ~cmd_ready
//   data_in             asynchronous bus level
//   data_out, data_oe   open-drain drive: data_out is 0, data_oe=1 pulls low
//   crc_out[7:0]        running CRC-8 (ONE_WIRE_CRC_EN only)
module one_wire_master #(
    parameter int unsigned CLKS_PER_US = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       presence,
    output logic       busy,
    input  logic       data_in,
    output logic       data_out,
    output logic       data_oe
`ifdef ONE_WIRE_CRC_EN
    ,
    output logic [7:0] crc_out
`endif
);

    localparam int unsigned T_RST_LOW   = 480 * CLKS_PER_US;
    localparam int unsigned T_RST_SAMP  = 70 * CLKS_PER_US;
    localparam int unsigned T_RST_REC   = 410 * CLKS_PER_US;
    localparam int unsigned T_LOW0      = 60 * CLKS_PER_US;
    localparam int unsigned T_LOW1      = 6 * CLKS_PER_US;
    localparam int unsigned T_REL0      = 10 * CLKS_PER_US;
    localparam int unsigned T_REL1      = 64 * CLKS_PER_US;
    localparam int unsigned T_RD_SAMP   = 9 * CLKS_PER_US;
    localparam int unsigned TW          = $clog2(T_RST_LOW + 1);

    typedef enum logic [2:0] {
        IDLE, RST_LOW, RST_WAIT, RST_REC, SLOT_LOW, SLOT_REL, DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_RESET = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_NOP   = 2'b11
    } op_t;

    state_t          state, next_state;
    op_t             op_reg;
    logic [TW-1:0]   timer, load_val, sample_at;
    logic            load;
    logic            accept, take_presence, take_bit, bit_done;
    logic [2:0]      bit_cnt, nxt_idx;
    logic [7:0]      data_reg, shift_reg;
    logic [1:0]      sync;
    logic            bus, last, wr0_now;

    assign bus       = sync[1];
    assign last      = (bit_cnt == 3'd7);
    assign nxt_idx   = bit_cnt + 3'd1;
    assign wr0_now   = (op_reg == OP_WRITE) && !data_reg[bit_cnt];
    assign data_out  = 1'b0;
    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;
    assign rsp_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // data_oe is registered from the state, so the pin lags the state by one
    // cycle. The final release phase (reset recovery, last slot release) is
    // loaded one cycle longer so the full release time holds at the pin.
    always_comb begin
        next_state    = state;
        load          = 1'b0;
        load_val      = '0;
        sample_at     = '0;
        accept        = 1'b0;
        take_presence = 1'b0;
        take_bit      = 1'b0;
        bit_done      = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    case (op_t'(cmd_op))
                        OP_RESET: begin
                            next_state = RST_LOW;
                            load       = 1'b1;
                            load_val   = TW'(T_RST_LOW - 1);
                        end
                        OP_WRITE, OP_READ: begin
                            next_state = SLOT_LOW;
                            load       = 1'b1;
                            load_val   = (op_t'(cmd_op) == OP_WRITE && !cmd_data[0])
                                         ? TW'(T_LOW0 - 1) : TW'(T_LOW1 - 1);
                        end
                        default: next_state = DONE;
                    endcase
                end
            end
            RST_LOW: begin
                if (timer == '0) begin
                    next_state = RST_WAIT;
                    load       = 1'b1;
                    load_val   = TW'(T_RST_SAMP - 1);
                end
            end
            RST_WAIT: begin
                if (timer == '0) begin
                    take_presence = 1'b1;
                    next_state    = RST_REC;
                    load          = 1'b1;
                    load_val      = TW'(T_RST_REC);
                end
            end
            RST_REC: begin
                if (timer == '0) next_state = DONE;
            end
            SLOT_LOW: begin
                if (timer == '0) begin
                    next_state = SLOT_REL;
                    load       = 1'b1;
                    load_val   = wr0_now ? TW'(T_REL0 - 1) : TW'(T_REL1 - 1);
                    if (last) load_val = load_val + 1'b1;
                end
            end
            SLOT_REL: begin
                // Timer value reached 9us after entering the release phase.
                sample_at = last ? TW'(T_REL1 - T_RD_SAMP) : TW'(T_REL1 - T_RD_SAMP - 1);
                if (op_reg == OP_READ && timer == sample_at) take_bit = 1'b1;
                if (timer == '0) begin
                    bit_done = 1'b1;
                    if (last) begin
                        next_state = DONE;
                    end else begin
                        next_state = SLOT_LOW;
                        load       = 1'b1;
                        load_val   = (op_reg == OP_WRITE && !data_reg[nxt_idx])
                                     ? TW'(T_LOW0 - 1) : TW'(T_LOW1 - 1);
                    end
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer     <= '0;
            bit_cnt   <= '0;
            op_reg    <= OP_RESET;
            data_reg  <= '0;
            shift_reg <= '0;
            rsp_data  <= '0;
            presence  <= 1'b0;
            data_oe   <= 1'b0;
            sync      <= 2'b11;
        end else begin
            sync    <= {sync[0], data_in};
            data_oe <= (state == RST_LOW) || (state == SLOT_LOW);

            if (load)              timer <= load_val;
            else if (timer != '0)  timer <= timer - 1'b1;

            if (accept) begin
                op_reg    <= op_t'(cmd_op);
                data_reg  <= cmd_data;
                bit_cnt   <= '0;
                shift_reg <= '0;
            end

            if (take_presence) presence <= ~bus;
            if (take_bit)      shift_reg[bit_cnt] <= bus;
            if (bit_done && !last) bit_cnt <= nxt_idx;

            if (next_state == DONE && state != DONE)
                rsp_data <= (state != IDLE && op_reg == OP_READ) ? shift_reg : '0;
        end
    end

`ifdef ONE_WIRE_CRC_EN
    logic [7:0] crc;

    // Reflected x^8+x^5+x^4+1, one bit per slot.
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        return {1'b0, c[7:1]} ^ (fb ? 8'h8C : 8'h00);
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            crc <= '0;
        else if (accept && op_t'(cmd_op) == OP_RESET)
            crc <= '0;
        else if (take_bit)
            crc <= crc_step(crc, bus);
        else if (bit_done && op_reg == OP_WRITE)
            crc <= crc_step(crc, data_reg[bit_cnt]);
    end

    assign crc_out = crc;
`endif

endmodule

// File: tb/tb_one_wire_master.sv
// Self-checking bench for one_wire_master (CLKS_PER_US = 10).
// A slave model on the bus answers bus resets with a presence pulse and
// drives bytes LSB first during read slots; the expected results come from
// the byte-level behaviour of the bus (pulse widths, slot period, latency).
module tb_one_wire_master;

    localparam int unsigned C = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       presence;
    logic       busy;
    logic       data_in;
    logic       data_out;
    logic       data_oe;
`ifdef ONE_WIRE_CRC_EN
    logic [7:0] crc_out;
`endif

    always #5 clk = ~clk;

    one_wire_master #(.CLKS_PER_US(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .presence  (presence),
        .busy      (busy),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe)
`ifdef ONE_WIRE_CRC_EN
        ,
        .crc_out   (crc_out)
`endif
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus and slave model
    logic        slave_pull;
    int          slave_mode = 0;      // 0 none, 1 presence responder, 2 read responder
    logic [7:0]  slave_byte = 8'h00;
    logic [2:0]  rd_idx = 3'd0;
    logic        oe_d = 1'b0;
    logic        pres_armed = 1'b0;
    int unsigned low_cnt = 0;
    int unsigned rel_cnt = 0;
    int unsigned pull_cnt = 0;
    int unsigned rsp_pulses = 0;
    int unsigned pulse_q[$];
    int unsigned rise_q[$];

    assign slave_pull = (pull_cnt != 0) || (pres_armed && rel_cnt >= 15 * C && rel_cnt < 240 * C);
    assign data_in    = (data_oe ? data_out : 1'b1) & ~slave_pull;

    always @(negedge clk) begin
        oe_d <= data_oe;
        if (rsp_valid) rsp_pulses <= rsp_pulses + 1;
        if (pull_cnt != 0) pull_cnt <= pull_cnt - 1;
        if (data_oe) begin
            if (!oe_d) begin
                low_cnt <= 1;
                rise_q.push_back(cyc);
                pres_armed <= 1'b0;
                if (slave_mode == 2) begin
                    pull_cnt <= slave_byte[rd_idx] ? 0 : 30 * C;
                    rd_idx   <= rd_idx + 3'd1;
                end
            end else begin
                low_cnt <= low_cnt + 1;
            end
        end else begin
            if (oe_d) begin
                pulse_q.push_back(low_cnt);
                rel_cnt <= 1;
                if (slave_mode == 1 && low_cnt >= 400 * C) pres_armed <= 1'b1;
            end else begin
                rel_cnt <= rel_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command and wait (bounded) for its response.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, output int unsigned lat);
        int unsigned t0;
        int unsigned n;
        n = 0;
        while (!cmd_ready && n < 20000) begin @(negedge clk); n++; end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        t0        = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_data  = 8'($urandom);
        n = 0;
        while (!rsp_valid && n < 20000) begin @(negedge clk); n++; end
        lat = rsp_valid ? cyc - t0 : 32'hFFFF_FFFF;
        @(negedge clk);
    endtask

    function automatic logic [7:0] crc_model(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 8'h8C;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Writes byte w and checks each low pulse width and slot period.
    task automatic write_and_check(input logic [7:0] w);
        int unsigned lat, pb, rb, p0;
        pb = pulse_q.size();
        rb = rise_q.size();
        p0 = rsp_pulses;
        run_cmd(2'b01, w, lat);
        check("wr_latency", lat, 560 * C + 2);
        check("wr_rsp_data", 32'(rsp_data), 0);
        check("wr_rsp_pulses", rsp_pulses, p0 + 1);
        check("wr_pulse_count", pulse_q.size() - pb, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wr_%02h_low_bit%0d", w, i), pulse_q[pb + i], w[i] ? 6 * C : 60 * C);
            if (i > 0) check($sformatf("wr_%02h_slot%0d", w, i), rise_q[rb + i] - rise_q[rb + i - 1], 70 * C);
        end
    endtask

    task automatic read_and_check(input logic [7:0] b);
        int unsigned lat, p0;
        slave_mode = 2;
        slave_byte = b;
        p0 = rsp_pulses;
        run_cmd(2'b10, 8'($urandom), lat);
        slave_mode = 0;
        check("rd_latency", lat, 560 * C + 2);
        check($sformatf("rd_data_%02h", b), 32'(rsp_data), 32'(b));
        check("rd_rsp_pulses", rsp_pulses, p0 + 1);
    endtask

    initial begin
        int unsigned lat, pb, p0;
        logic [7:0] rb;
        logic [7:0] crc_exp;
        logic [7:0] rom[7];

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_data_oe", 32'(data_oe), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_presence", 32'(presence), 0);
        check("rst_data_out", 32'(data_out), 0);
        rst = 1'b0;
        @(negedge clk);

        // Bus reset with a responding slave
        slave_mode = 1;
        pb = pulse_q.size();
        p0 = rsp_pulses;
        run_cmd(2'b00, 8'h00, lat);
        slave_mode = 0;
        check("reset_latency", lat, 960 * C + 2);
        check("reset_presence", 32'(presence), 1);
        check("reset_rsp_data", 32'(rsp_data), 0);
        check("reset_low_width", pulse_q[pb], 480 * C);
        check("reset_rsp_pulses", rsp_pulses, p0 + 1);

        write_and_check(8'hCC);
        check("presence_held", 32'(presence), 1);
        read_and_check(8'hA5);

        // Bus reset with no slave; rsp_data returns to 0 after a read
        p0 = rsp_pulses;
        run_cmd(2'b00, 8'hFF, lat);
        check("noslave_presence", 32'(presence), 0);
        check("noslave_rsp_data", 32'(rsp_data), 0);
        check("noslave_latency", lat, 960 * C + 2);
        check("noslave_rsp_pulses", rsp_pulses, p0 + 1);

`ifndef ONE_WIRE_CRC_EN
        for (int k = 0; k < 2; k++) begin
            write_and_check(8'($urandom));
            rb = 8'($urandom_range(1, 255));
            read_and_check(rb);
        end
`endif

        // Reserved op completes in one cycle with rsp_data 0
        read_and_check(8'h5A);
        run_cmd(2'b11, 8'h77, lat);
        check("nop_latency", lat, 1);
        check("nop_rsp_data", 32'(rsp_data), 0);

        // rst during the low phase of a write-0 slot
        while (!cmd_ready) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_data  = 8'h00;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (20 * C) @(negedge clk);
        check("abort_oe_before", 32'(data_oe), 1);
        p0 = rsp_pulses;
        rst = 1'b1;
        @(negedge clk);
        check("abort_oe_after", 32'(data_oe), 0);
        check("abort_cmd_ready", 32'(cmd_ready), 1);
        rst = 1'b0;
        repeat (100 * C) @(negedge clk);
        check("abort_no_rsp", rsp_pulses, p0);
        check("abort_oe_idle", 32'(data_oe), 0);

`ifdef ONE_WIRE_CRC_EN
        run_cmd(2'b00, 8'h00, lat);
        check("crc_cleared", 32'(crc_out), 0);
        crc_exp = 8'h00;
        write_and_check(8'h33);
        crc_exp = crc_model(crc_exp, 8'h33);
        rom[0] = 8'h02; rom[1] = 8'h1C; rom[2] = 8'hB8; rom[3] = 8'h01;
        rom[4] = 8'h00; rom[5] = 8'h00; rom[6] = 8'h00;
        for (int i = 0; i < 7; i++) begin
            read_and_check(rom[i]);
            crc_exp = crc_model(crc_exp, rom[i]);
        end
        check("crc_after_rom", 32'(crc_out), 32'(crc_exp));
        read_and_check(crc_exp);
        check("crc_residue", 32'(crc_out), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
